dac_frame_serializer: RTL

Transmit-side companion to the chip's serial DAC-code loader. Takes a parallel DAC data word and a conversion-control word and shifts each out on its own serial lane. Each frame is one marker bit followed by the word, LSB first, so that the loader's 9-bit capture registers latch exactly one word and then lock. Sits in the test or companion FPGA and drives the loader's data and conversion inputs from the same clock.

---
 rtl/dac_frame_serializer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/dac_frame_serializer.sv
// Dual-lane serializer feeding the DAC-code loader: one marker bit, then W bits LSB first per lane.
// Optional 8-bit completed-frame counter output enabled by DAC_SER_FRAME_CNT_EN.
module dac_frame_serializer #(
   parameter int W   = 8,
   parameter int GAP = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         tx_valid,
   output logic         tx_ready,
   input  logic [W-1:0] tx_data,
   input  logic [W-1:0] tx_conver,
   output logic         sd_data,
   output logic         sd_conver,
   output logic         busy,
   output logic         frame_done
`ifdef DAC_SER_FRAME_CNT_EN
   ,
   output logic [7:0]   frame_cnt
`endif
);

   localparam int CW = (W > 1) ? $clog2(W) : 1;
   localparam logic [CW-1:0] BIT_LAST = CW'(W - 1);
   localparam logic [3:0]    GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

   typedef enum logic [1:0] {S_IDLE, S_MARK, S_DATA, S_GAP} state_t;

   state_t          r_state;
   logic [W-1:0]    r_shA;
   logic [W-1:0]    r_shB;
   logic [CW-1:0]   r_bitCnt;
   logic [3:0]      r_gapCnt;
   logic            r_sdA;
   logic            r_sdB;
   logic            r_ready;
   logic            r_busy;
   logic            r_done;
`ifdef DAC_SER_FRAME_CNT_EN
   logic [7:0]      r_frameCnt;
`endif

   // Lanes stay low outside a frame so the loader never sees a stray marker.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_shA    <= '0;
         r_shB    <= '0;
         r_bitCnt <= '0;
         r_gapCnt <= '0;
         r_sdA    <= 1'b0;
         r_sdB    <= 1'b0;
         r_ready  <= 1'b1;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
`ifdef DAC_SER_FRAME_CNT_EN
         r_frameCnt <= '0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (tx_valid) begin
                  r_shA   <= tx_data;
                  r_shB   <= tx_conver;
                  r_sdA   <= 1'b1;
                  r_sdB   <= 1'b1;
                  r_ready <= 1'b0;
                  r_busy  <= 1'b1;
                  r_state <= S_MARK;
               end
            end
            S_MARK: begin
               r_sdA    <= r_shA[0];
               r_sdB    <= r_shB[0];
               r_shA    <= r_shA >> 1;
               r_shB    <= r_shB >> 1;
               r_bitCnt <= '0;
               r_state  <= S_DATA;
            end
            S_DATA: begin
               if (r_bitCnt == BIT_LAST) begin
                  r_sdA    <= 1'b0;
                  r_sdB    <= 1'b0;
                  r_done   <= 1'b1;
                  r_gapCnt <= '0;
`ifdef DAC_SER_FRAME_CNT_EN
                  r_frameCnt <= r_frameCnt + 8'd1;
`endif
                  if (GAP == 0) begin
                     r_state <= S_IDLE;
                     r_ready <= 1'b1;
                     r_busy  <= 1'b0;
                  end else begin
                     r_state <= S_GAP;
                  end
               end else begin
                  r_sdA    <= r_shA[0];
                  r_sdB    <= r_shB[0];
                  r_shA    <= r_shA >> 1;
                  r_shB    <= r_shB >> 1;
                  r_bitCnt <= r_bitCnt + 1'b1;
               end
            end
            S_GAP: begin
               if (r_gapCnt == GAP_LAST) begin
                  r_state <= S_IDLE;
                  r_ready <= 1'b1;
                  r_busy  <= 1'b0;
               end else begin
                  r_gapCnt <= r_gapCnt + 4'd1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_sdA   <= 1'b0;
               r_sdB   <= 1'b0;
               r_ready <= 1'b1;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign tx_ready   = r_ready;
   assign sd_data    = r_sdA;
   assign sd_conver  = r_sdB;
   assign busy       = r_busy;
   assign frame_done = r_done;
`ifdef DAC_SER_FRAME_CNT_EN
   assign frame_cnt  = r_frameCnt;
`endif

endmodule
